// File: rtl/inst_encoder.sv
// Packs instruction field bundles into 32-bit ARM-format words and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
module inst_encoder #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_op,
  input  logic              in_s,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       fifo_r [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_r;
  logic [PTR_W:0]    rd_ptr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] count_r;
  logic              err_r;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       enc_word_s;

  // Type 3 never reaches the FIFO, so its encoding is a don't-care zero.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  typ,
    input logic [3:0]  cond,
    input logic [3:0]  op,
    input logic        s,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [3:0]  rm,
    input logic [23:0] imm
  );
    logic [31:0] w;
    case (typ)
      2'd0:    w = {cond, 2'b00, 1'b0, op, s, rn, rd, 8'h00, rm};
      2'd1:    w = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rn, rd, imm[11:0]};
      2'd2:    w = {cond, 3'b101, 1'b0, imm};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // The extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

  assign in_ready    = (state_r == RUN) && !fifo_full_s;
  assign mem_req     = ((state_r == RUN) || (state_r == DRAIN)) && !fifo_empty_s;
  assign mem_addr    = addr_r;
  assign mem_wdata   = fifo_r[rd_ptr_r[PTR_W-1:0]];
  assign busy        = (state_r != IDLE);
  assign done        = (state_r == DONE);
  assign err_illegal = err_r;
  assign word_count  = count_r;

  assign accept_s   = in_valid && in_ready;
  assign push_s     = accept_s && (in_type != 2'd3);
  assign pop_s      = mem_req && mem_ack;
  assign enc_word_s = encode_word(in_type, in_cond, in_op, in_s, in_rn, in_rd, in_rm, in_imm);

  // Session sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (finish) state_nxt_s = DRAIN;
        else        state_nxt_s = RUN;
      end
      DRAIN: begin
        if (fifo_empty_s) state_nxt_s = DONE;
        else              state_nxt_s = DRAIN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Encoded-word FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r[PTR_W-1:0]] <= enc_word_s;
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Write address, acked-word count and sticky illegal flag for the session.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      addr_r  <= base_addr;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        addr_r  <= addr_r + ADDR_W'(3'd4);
        count_r <= count_r + ADDR_W'(1'b1);
      end
      if (accept_s && (in_type == 2'd3)) err_r <= 1'b1;
    end
  end

endmodule
